// File: rtl/fetch_utlb_stage_pkg.sv
// Shared definitions for the fetch uTLB stage: exception codes, FSM states,
// the uTLB payload layout and the unmapped-segment decode.
package fetch_utlb_stage_pkg;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_TLBL = 5'd2;

    typedef enum logic [1:0] {
        CHECK = 2'd0,
        QUERY = 2'd1,
        REQ   = 2'd2
    } fetch_state_e;

    // Translation payload held per uTLB entry and in the bypass register
    typedef struct packed {
        logic [19:0] pfn;
        logic        miss;
        logic        invalid;
        logic [2:0]  cattr;
    } utlb_data_t;

    localparam int UTLB_DATA_W = $bits(utlb_data_t);

    // kseg0 (0x8000_0000) and kseg1 (0xA000_0000) bypass translation
    function automatic logic is_kseg01(input logic [31:0] va);
        return va[31:30] == 2'b10;
    endfunction

endpackage

// File: rtl/fetch_utlb_stage_cam.sv
// fetch_utlb_cam: fully associative micro-TLB. Parallel VPN compare, onehot
// OR-mux of the matching payload, round-robin victim replacement, and a
// whole-array flush. Payload registers carry no reset; only valid bits do.
module fetch_utlb_cam
    import fetch_utlb_stage_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [19:0]            lookup_vpn_i,
    output logic                   hit_o,
    output logic [UTLB_DATA_W-1:0] hit_data_o,
    input  logic                   flush_i,
    input  logic                   refill_i,
    input  logic [19:0]            refill_vpn_i,
    input  logic [UTLB_DATA_W-1:0] refill_data_i
);

    logic [ENTRIES-1:0]                  valid_q;
    logic [ENTRIES-1:0][19:0]            vpn_q;
    logic [ENTRIES-1:0][UTLB_DATA_W-1:0] data_q;
    logic [IDX_W-1:0]                    victim_q;
    logic [IDX_W-1:0]                    victim_d;
    logic [ENTRIES-1:0]                  match;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_match
        assign match[i] = valid_q[i] && (vpn_q[i] == lookup_vpn_i);
    end

    assign hit_o = |match;

    // Onehot OR-mux: at most one entry may match a given VPN
    always_comb begin
        hit_data_o = '0;
        for (int i = 0; i < ENTRIES; i++)
            hit_data_o = hit_data_o | ({UTLB_DATA_W{match[i]}} & data_q[i]);
    end

    // Victim pointer wraps at ENTRIES (also covers the single-entry case)
    always_comb begin
        victim_d = (victim_q == IDX_W'(ENTRIES - 1)) ? '0 : victim_q + 1'b1;
    end

    // Valid bits and victim pointer; flush wins over a refill
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q  <= '0;
            victim_q <= '0;
        end else if (flush_i) begin
            valid_q  <= '0;
        end else if (refill_i) begin
            for (int i = 0; i < ENTRIES; i++)
                if (victim_q == IDX_W'(i)) valid_q[i] <= 1'b1;
            victim_q <= victim_d;
        end
    end

    // Entry payload written into the victim slot on refill
    always_ff @(posedge clk) begin
        if (refill_i && !flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (victim_q == IDX_W'(i)) begin
                    vpn_q[i]  <= refill_vpn_i;
                    data_q[i] <= refill_data_i;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_utlb_stage.sv
// fetch_utlb_stage: IF_req stage. Translates pc_i by kseg0/1 bypass, uTLB hit,
// or a two-cycle main-TLB walk (CHECK -> QUERY -> REQ), issues the bus request
// and registers pc/exception/cancel status toward IF_wait.
// Optional: define UTLB_PERFCNT_EN to add the perfcnt_utlb_miss counter.
module fetch_utlb_stage
    import fetch_utlb_stage_pkg::*;
#(
    parameter int UTLB_ENTRIES = 4,
    parameter int UTLB_IDX_W   = (UTLB_ENTRIES > 1) ? $clog2(UTLB_ENTRIES) : 1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic        inst_cache,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        tlb_write,
    output logic [31:0] tlb_vaddr,
    input  logic [31:0] tlb_paddr,
    input  logic        tlb_miss,
    input  logic        tlb_invalid,
    input  logic [2:0]  tlb_cattr,
    input  logic [2:0]  config_k0,
    output logic        ready_o,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic        cancelled_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [31:0] pc_o,
    output logic [4:0]  exccode_o,
    input  logic        cancel_i,
    input  logic        commit_i,
    output logic [31:0] perfcnt_fetch_waitreq
`ifdef UTLB_PERFCNT_EN
    ,
    output logic [31:0] perfcnt_utlb_miss
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_save_q;
    utlb_data_t   cap_q;
    logic         cancel_save_q;
    logic         valid_q, cancelled_q, exc_q, exc_miss_q;
    logic [31:0]  pc_q;
    logic [4:0]   exccode_q;
    logic [31:0]  waitreq_q;

    logic         act, kseg01, kseg0, in_check, in_req;
    logic         cam_hit, chk_hit, adel, tlb_fault, req_exc, addr_acc, refill;
    logic [UTLB_DATA_W-1:0] cam_raw;
    utlb_data_t   cam_data, sel_data;
    logic         unused_cattr;

    fetch_utlb_cam #(
        .ENTRIES (UTLB_ENTRIES),
        .IDX_W   (UTLB_IDX_W)
    ) u_cam (
        .clk           (clk),
        .resetn        (resetn),
        .lookup_vpn_i  (pc_i[31:12]),
        .hit_o         (cam_hit),
        .hit_data_o    (cam_raw),
        .flush_i       (tlb_write),
        .refill_i      (refill),
        .refill_vpn_i  (pc_save_q[31:12]),
        .refill_data_i ({tlb_paddr[31:12], tlb_miss, tlb_invalid, tlb_cattr})
    );

    assign cam_data     = cam_raw;
    assign unused_cattr = ^{config_k0[2:1], cam_data.cattr[2:1], cap_q.cattr[2:1]};

    // Nothing is driven out while reset is held or no pc is offered
    assign act      = valid_i && resetn;
    assign kseg01   = is_kseg01(pc_i);
    assign kseg0    = pc_i[31:29] == 3'b100;
    assign in_check = state_q == CHECK;
    assign in_req   = state_q == REQ;
    assign chk_hit  = in_check && !kseg01 && cam_hit;
    assign adel     = in_check && (pc_i[1:0] != 2'b00);
    assign sel_data = in_req ? cap_q : cam_data;

    assign tlb_fault = (chk_hit || in_req) && (sel_data.miss || sel_data.invalid);
    assign req_exc   = act && (adel || tlb_fault);
    assign inst_req  = act && ready_i && !req_exc &&
                       ((in_check && (kseg01 || chk_hit)) || in_req);
    // A well-behaved bus only acks a live request; gate anyway
    assign addr_acc  = inst_req && inst_addr_ok;
    assign ready_o   = ready_i && (addr_acc || req_exc);
    assign tlb_vaddr = act ? (in_check ? pc_i : pc_save_q) : 32'h0;

    // No refill when the main TLB changes or the pipe is flushed this cycle
    assign refill = resetn && (state_q == QUERY) && !tlb_write && !cancel_i;

    // Physical address / cacheability for whichever path is issuing
    always_comb begin
        inst_addr  = 32'h0;
        inst_cache = 1'b0;
        if (act) begin
            if (in_req) begin
                inst_addr  = {cap_q.pfn, pc_save_q[11:0]};
                inst_cache = cap_q.cattr[0];
            end else if (in_check && kseg01) begin
                inst_addr  = {3'b000, pc_i[28:0]};
                inst_cache = kseg0 && config_k0[0];
            end else if (chk_hit) begin
                inst_addr  = {cam_data.pfn, pc_i[11:0]};
                inst_cache = cam_data.cattr[0];
            end
        end
    end

    // Next-state: walk the main TLB on a uTLB miss; cancel always returns to CHECK.
    // A misaligned pc is retired as ADEL in CHECK and never starts a walk.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CHECK: if (valid_i && ready_i && !kseg01 && !cam_hit && !adel) state_d = QUERY;
            QUERY: state_d = REQ;
            REQ:   if (addr_acc || ((cap_q.miss || cap_q.invalid) && ready_i)) state_d = CHECK;
            default: state_d = CHECK;
        endcase
        if (cancel_i) state_d = CHECK;
    end

    // FSM, walk pc and the one-entry bypass of the main-TLB result
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= CHECK;
            pc_save_q <= 32'h0;
            cap_q     <= '0;
        end else begin
            state_q <= state_d;
            if (in_check && state_d == QUERY) pc_save_q <= pc_i;
            if (state_q == QUERY)
                cap_q <= '{pfn: tlb_paddr[31:12], miss: tlb_miss,
                           invalid: tlb_invalid, cattr: tlb_cattr};
        end
    end

    // Pending cancel for the next output; clearing has priority
    always_ff @(posedge clk) begin
        if (!resetn)                   cancel_save_q <= 1'b0;
        else if (ready_i || commit_i)  cancel_save_q <= 1'b0;
        else if (cancel_i && valid_i)  cancel_save_q <= 1'b1;
    end

    // Output register toward IF_wait, advanced whenever downstream is ready
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q     <= 1'b0;
            pc_q        <= 32'h0;
            cancelled_q <= 1'b0;
            exc_q       <= 1'b0;
            exc_miss_q  <= 1'b0;
            exccode_q   <= 5'd0;
        end else if (ready_i) begin
            valid_q     <= addr_acc || req_exc;
            pc_q        <= in_check ? pc_i : pc_save_q;
            cancelled_q <= cancel_i || cancel_save_q;
            exc_q       <= req_exc;
            exc_miss_q  <= req_exc && !adel && sel_data.miss;
            exccode_q   <= !req_exc ? 5'd0 : (adel ? EXC_ADEL : EXC_TLBL);
        end
    end

    // Cycles the bus stalls an outstanding request
    always_ff @(posedge clk) begin
        if (!resetn)                       waitreq_q <= 32'h0;
        else if (inst_req && !inst_addr_ok) waitreq_q <= waitreq_q + 32'd1;
    end

    assign valid_o               = valid_q;
    assign pc_o                  = pc_q;
    assign cancelled_o           = cancelled_q;
    assign exc_o                 = exc_q;
    assign exc_miss_o            = exc_miss_q;
    assign exccode_o             = exccode_q;
    assign perfcnt_fetch_waitreq = waitreq_q;

`ifdef UTLB_PERFCNT_EN
    logic [31:0] utlb_miss_q;

    // One count per main-TLB walk started
    always_ff @(posedge clk) begin
        if (!resetn)                          utlb_miss_q <= 32'h0;
        else if (in_check && state_d == QUERY) utlb_miss_q <= utlb_miss_q + 32'd1;
    end

    assign perfcnt_utlb_miss = utlb_miss_q;
`else
    // uTLB miss counter not built
`endif

endmodule

// File: tb/tb_fetch_utlb_stage.sv
// Bench for fetch_utlb_stage: directed scenarios then random fetches, checked
// against a page-table + round-robin uTLB reference with expected latencies.
module tb_fetch_utlb_stage;

    localparam int ENT = 4;

    typedef struct packed {
        logic [19:0] pfn;
        logic        miss;
        logic        inv;
        logic [2:0]  cattr;
    } pte_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_cache, inst_addr_ok, tlb_write;
    logic [31:0] inst_addr, tlb_vaddr, tlb_paddr;
    logic        tlb_miss, tlb_invalid;
    logic [2:0]  tlb_cattr, config_k0;
    logic        ready_o, valid_i, ready_i, valid_o, cancelled_o, exc_o, exc_miss_o;
    logic [31:0] pc_i, pc_o, perfcnt_fetch_waitreq;
    logic [4:0]  exccode_o;
    logic        cancel_i, commit_i;
`ifdef UTLB_PERFCNT_EN
    logic [31:0] perfcnt_utlb_miss;
`endif

    fetch_utlb_stage #(.UTLB_ENTRIES(ENT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .tlb_write(tlb_write), .tlb_vaddr(tlb_vaddr),
        .tlb_paddr(tlb_paddr), .tlb_miss(tlb_miss), .tlb_invalid(tlb_invalid),
        .tlb_cattr(tlb_cattr), .config_k0(config_k0), .ready_o(ready_o),
        .valid_i(valid_i), .pc_i(pc_i), .ready_i(ready_i), .valid_o(valid_o),
        .cancelled_o(cancelled_o), .exc_o(exc_o), .exc_miss_o(exc_miss_o),
        .pc_o(pc_o), .exccode_o(exccode_o), .cancel_i(cancel_i), .commit_i(commit_i),
        .perfcnt_fetch_waitreq(perfcnt_fetch_waitreq)
`ifdef UTLB_PERFCNT_EN
        , .perfcnt_utlb_miss(perfcnt_utlb_miss)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference uTLB: which pages are cached, and the round-robin slot
    bit          mv   [ENT];
    logic [19:0] mvpn [ENT];
    int          mvp, mwait, mmiss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic pte_t pt(input logic [19:0] v);
        pte_t t;
        t.pfn = v ^ 20'hA5A5A; t.miss = 1'b0; t.inv = 1'b0; t.cattr = {2'b01, v[0]};
        if (v == 20'h00400) begin t.pfn = 20'h12345; t.cattr = 3'd3; end
        if (v == 20'h00777) t.miss = 1'b1;
        if (v == 20'h00778) t.inv  = 1'b1;
        return t;
    endfunction

    function automatic bit m_hit(input logic [19:0] v);
        for (int i = 0; i < ENT; i++) if (mv[i] && mvpn[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [19:0] pick(input int i);
        case (i)
            0: return 20'h00400; 1: return 20'h00401; 2: return 20'h00402;
            3: return 20'h00403; 4: return 20'h00404; 5: return 20'h00405;
            6: return 20'h00406; 7: return 20'h00777; 8: return 20'h00778;
            default: return 20'h7FFF0;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) mv[i] = 1'b0;
        mvp = 0; mwait = 0; mmiss = 0;
    endtask

    task automatic m_flush();
        for (int i = 0; i < ENT; i++) mv[i] = 1'b0;
    endtask

    // Clock edge; main TLB answers one cycle after the address it was shown
    task automatic tick();
        logic [31:0] va;
        pte_t t;
        va = tlb_vaddr;
        @(posedge clk); #1;
        t = pt(va[31:12]);
        tlb_paddr = {t.pfn, 12'h000}; tlb_miss = t.miss; tlb_invalid = t.inv; tlb_cattr = t.cattr;
    endtask

    task automatic idle(input bit flush);
        valid_i = 1'b0; tlb_write = flush; inst_addr_ok = 1'b0;
        #1;
        chk("idle_req", inst_req, 0);
        chk("idle_rdy", ready_o, 0);
        if (flush) m_flush();
        tick();
        tlb_write = 1'b0;
    endtask

    // One fetch: dly = bus wait cycles, flushq = tlb_write during the walk's QUERY cycle
    task automatic fetch(input logic [31:0] pc, input int dly, input bit flushq, input bit expcan);
        pte_t t;
        bit ks, adel, hit, fault, exc;
        int lat, last;
        logic [31:0] ea;
        logic ec;
        ks    = pc[31:30] == 2'b10;
        adel  = pc[1:0] != 2'b00;
        t     = pt(pc[31:12]);
        hit   = !ks && m_hit(pc[31:12]);
        lat   = (adel || ks || hit) ? 0 : 2;
        fault = !ks && (t.miss || t.inv);
        exc   = adel || fault;
        ea    = ks ? {3'b000, pc[28:0]} : {t.pfn, pc[11:0]};
        ec    = ks ? (pc[29] == 1'b0 && config_k0[0]) : t.cattr[0];
        last  = lat + (exc ? 0 : dly);
        if (lat == 2) mmiss++;
        valid_i = 1'b1; pc_i = pc; ready_i = 1'b1; cancel_i = 1'b0;
        for (int k = 0; k <= last; k++) begin
            tlb_write    = flushq && lat == 2 && k == 1;
            inst_addr_ok = 1'b0;
            #1;
            if (k < lat) begin
                chk("wait_req", inst_req, 0);
                chk("wait_rdy", ready_o, 0);
            end else if (exc) begin
                chk("exc_req", inst_req, 0);
                chk("exc_rdy", ready_o, 1);
            end else begin
                chk("req", inst_req, 1);
                chk("addr", inst_addr, ea);
                chk("cache", inst_cache, ec);
                if (k == last) inst_addr_ok = 1'b1; else mwait++;
                #1;
                chk("rdy", ready_o, k == last);
            end
            if (lat == 2 && k == 1) begin
                if (tlb_write) m_flush();
                else begin mv[mvp] = 1'b1; mvpn[mvp] = pc[31:12]; mvp = (mvp + 1) % ENT; end
            end
            chk("onehot", $onehot0(dut.u_cam.match), 1);
            tick();
        end
        tlb_write = 1'b0; inst_addr_ok = 1'b0; valid_i = 1'b0;
        chk("valid_o", valid_o, 1);
        chk("pc_o", pc_o, pc);
        chk("exc_o", exc_o, exc);
        chk("exc_miss_o", exc_miss_o, !adel && fault && t.miss);
        chk("exccode_o", exccode_o, adel ? 5'd4 : (fault ? 5'd2 : 5'd0));
        chk("cancelled_o", cancelled_o, expcan);
    endtask

    initial begin
        resetn = 1'b0; valid_i = 1'b1; pc_i = 32'h8000_0000; ready_i = 1'b1;
        cancel_i = 1'b0; commit_i = 1'b0; inst_addr_ok = 1'b0; tlb_write = 1'b0;
        config_k0 = 3'd3; tlb_paddr = 32'h0; tlb_miss = 1'b0; tlb_invalid = 1'b0; tlb_cattr = 3'd0;
        m_reset();
        #1;
        chk("rst_req", inst_req, 0);
        chk("rst_rdy", ready_o, 0);
        tick(); tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_canc", cancelled_o, 0);
        chk("rst_exc", {exc_o, exc_miss_o, exccode_o}, 0);
        chk("rst_wait", perfcnt_fetch_waitreq, 0);
        valid_i = 1'b0; resetn = 1'b1;

        // Unmapped segments
        fetch(32'h8000_0100, 0, 0, 0);
        fetch(32'hA000_0040, 1, 0, 0);
        fetch(32'h8000_0104, 0, 0, 0);

        // Round-robin fill and eviction of the oldest page
        fetch(32'h0000_1000, 0, 0, 0);
        fetch(32'h0000_2000, 0, 0, 0);
        fetch(32'h0000_3000, 0, 0, 0);
        fetch(32'h0000_4000, 0, 0, 0);
        fetch(32'h0000_5000, 0, 0, 0);
        fetch(32'h0000_2ab4, 0, 0, 0);
        fetch(32'h0000_1000, 0, 0, 0);

        // Main-TLB walk then zero-latency hit; flush forces a new walk
        fetch(32'h0040_0000, 0, 0, 0);
        fetch(32'h0040_0004, 2, 0, 0);
        idle(1'b1);
        fetch(32'h0040_0008, 1, 0, 0);
        fetch(32'h0040_1000, 0, 1, 0);
        fetch(32'h0040_1004, 0, 0, 0);

        // Exceptions
        fetch(32'h0040_0002, 0, 0, 0);
        fetch(32'h0077_7000, 0, 0, 0);
        fetch(32'h0077_7010, 0, 0, 0);
        fetch(32'h0077_7011, 0, 0, 0);
        fetch(32'h0077_8000, 0, 0, 0);

        // Cancel while the walk result waits in REQ, downstream stalled
        idle(1'b1);
        valid_i = 1'b1; pc_i = 32'h0040_6010; ready_i = 1'b1; mmiss++;
        #1; chk("can_k0_req", inst_req, 0); tick();
        #1; mv[mvp] = 1'b1; mvpn[mvp] = 20'h00406; mvp = (mvp + 1) % ENT; tick();
        ready_i = 1'b0; cancel_i = 1'b1;
        #1; chk("can_req", inst_req, 0); chk("can_rdy", ready_o, 0); tick();
        cancel_i = 1'b0;
        fetch(32'h0040_6010, 0, 0, 1);
        fetch(32'h0040_6014, 0, 0, 0);

        // Random fetches over more pages than uTLB entries
        for (int n = 0; n < 150; n++) begin
            int r;
            logic [31:0] pc;
            r  = $urandom_range(0, 19);
            pc = {pick($urandom_range(0, 9)), 12'($urandom) & 12'hFFC};
            if (r == 0)      pc = {3'b100, 29'($urandom)} & 32'hFFFF_FFFC;
            else if (r == 1) pc = {3'b101, 29'($urandom)} & 32'hFFFF_FFFC;
            else if (r == 2) pc[1:0] = 2'($urandom_range(1, 3));
            else if (r == 3) idle(1'b1);
            fetch(pc, $urandom_range(0, 2), $urandom_range(0, 9) == 0, 0);
        end
        chk("perf_wait", perfcnt_fetch_waitreq, mwait);
`ifdef UTLB_PERFCNT_EN
        chk("perf_miss", perfcnt_utlb_miss, mmiss);
`endif

        // Reset in REQ: no request that cycle, uTLB emptied
        idle(1'b1);
        valid_i = 1'b1; pc_i = 32'h0040_3000; ready_i = 1'b1;
        #1; tick();
        #1; tick();
        resetn = 1'b0;
        #1; chk("rstreq_req", inst_req, 0); tick();
        resetn = 1'b1; valid_i = 1'b0; m_reset();
        chk("rstreq_valid", valid_o, 0);
        chk("rstreq_wait", perfcnt_fetch_waitreq, 0);
        fetch(32'h0040_3000, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
